// File: rtl/wb_dma_master_pkg.sv
// Shared encodings for the wishbone DMA master: bus cycle-type codes and FSM states.
package wb_dma_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [3:0] SEL_ALL     = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FIN
  } state_t;

endpackage

// File: rtl/wb_dma_master_if.sv
// Wishbone master-port bundle; signal names match the original flat ports.
interface wb_dma_master_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic [31:0] wbm_data_o;
  logic [31:0] wbm_data_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
           wbm_sel_o, wbm_we_o, wbm_data_o,
    input  wbm_data_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
           wbm_sel_o, wbm_we_o, wbm_data_o,
    output wbm_data_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/wb_dma_buf.sv
// Burst staging buffer: one synchronous write port, one asynchronous read port.
module wb_dma_buf #(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  // Capture read-burst data as each beat is acknowledged.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone DMA master: copies a word block via read bursts into a local buffer
// followed by write bursts out of it, chunked to the buffer depth.
module wb_dma_master
  import wb_dma_master_pkg::*;
#(
  parameter int unsigned BUF_ADDR_BITS = 4,
  parameter int unsigned LEN_BITS      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [29:0]         src_addr,
  input  logic [29:0]         dst_addr,
  input  logic [LEN_BITS-1:0] length,
  output logic                busy,
  output logic                done,
  output logic                err,
  wb_dma_master_if.master     bus
);

  localparam int unsigned CW = BUF_ADDR_BITS + 1;
  localparam logic [CW-1:0] MAX_CHUNK = {1'b1, {BUF_ADDR_BITS{1'b0}}};

  state_t                   state_q, state_d;
  logic                     gap_q, gap_d;
  logic [29:0]              src_q, src_d;
  logic [29:0]              dst_q, dst_d;
  logic [LEN_BITS-1:0]      rem_q, rem_d;
  logic [CW-1:0]            chunk_q, chunk_d;
  logic [BUF_ADDR_BITS-1:0] beat_q, beat_d;
  logic                     err_q, err_d;

  logic                     active;
  logic                     last_beat;
  logic [LEN_BITS-1:0]      rem_after;
  logic                     buf_we;
  logic [31:0]              buf_rdata;

  function automatic logic [CW-1:0] chunk_of(input logic [LEN_BITS-1:0] n);
    if (n >= LEN_BITS'(MAX_CHUNK)) return MAX_CHUNK;
    return n[CW-1:0];
  endfunction

  wb_dma_buf #(.ADDR_BITS(BUF_ADDR_BITS)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (beat_q),
    .wdata (bus.wbm_data_i),
    .raddr (beat_q),
    .rdata (buf_rdata)
  );

  // The one-cycle bus-idle gap between phases is a flag inside RD/WR rather
  // than separate states, so the bus strobe is simply "in RD/WR and not gap".
  assign active    = ((state_q == S_RD) || (state_q == S_WR)) && !gap_q;
  assign last_beat = ({1'b0, beat_q} == (chunk_q - CW'(1)));
  assign rem_after = rem_q - LEN_BITS'(chunk_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter updates and buffer write enable.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_FIN;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = length;
            chunk_d = chunk_of(length);
            beat_d  = '0;
            gap_d   = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus.wbm_err_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.wbm_ack_i) begin
          buf_we = 1'b1;
          src_d  = src_q + 30'd1;
          if (last_beat) begin
            beat_d  = '0;
            gap_d   = 1'b1;
            state_d = S_WR;
          end else begin
            beat_d = beat_q + BUF_ADDR_BITS'(1);
          end
        end
      end
      S_WR: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus.wbm_err_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.wbm_ack_i) begin
          dst_d = dst_q + 30'd1;
          if (last_beat) begin
            rem_d  = rem_after;
            beat_d = '0;
            if (rem_after != '0) begin
              chunk_d = chunk_of(rem_after);
              gap_d   = 1'b1;
              state_d = S_RD;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            beat_d = beat_q + BUF_ADDR_BITS'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state so reset drops them at once.
  always_comb begin
    bus.wbm_cyc_o  = active;
    bus.wbm_stb_o  = active;
    bus.wbm_we_o   = active && (state_q == S_WR);
    bus.wbm_addr_o = '0;
    bus.wbm_cti_o  = CTI_CLASSIC;
    bus.wbm_data_o = '0;
    if (active) begin
      bus.wbm_addr_o = (state_q == S_WR) ? dst_q : src_q;
      if (chunk_q == CW'(1))  bus.wbm_cti_o = CTI_CLASSIC;
      else if (last_beat)     bus.wbm_cti_o = CTI_END;
      else                    bus.wbm_cti_o = CTI_INCR;
      if (state_q == S_WR) bus.wbm_data_o = buf_rdata;
    end
  end

  assign bus.wbm_bte_o = BTE_LINEAR;
  assign bus.wbm_sel_o = SEL_ALL;

  assign busy = (state_q == S_RD) || (state_q == S_WR);
  assign done = (state_q == S_FIN);
  assign err  = err_q;

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master: a table of copy jobs run against a
// scripted wishbone slave, plus reset-mid-burst and start-while-busy sequences.
module tb_wb_dma_master;

  localparam int unsigned BUF  = 4;
  localparam int unsigned MAXB = 1 << BUF;

  typedef struct {
    logic [15:0] len;
    logic [29:0] src;
    logic [29:0] dst;
    int unsigned ws;
    int          errbeat;
    int unsigned exp_done;
    int unsigned exp_err;
    int unsigned exp_beats;
    logic [29:0] exp_last_dst;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [2:0]  cti;
    logic [31:0] data;
    int unsigned cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [29:0] src_addr = '0;
  logic [29:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, err;

  wb_dma_master_if bus ();

  wb_dma_master #(.BUF_ADDR_BITS(BUF), .LEN_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave configuration (written by the main sequence only).
  int unsigned cfg_ws = 0;
  int unsigned cfg_err_at = 32'hFFFF_FFFF;

  // Slave/monitor bookkeeping (written by the monitor only).
  beat_t       log_q[$];
  int unsigned done_q[$];
  int unsigned err_q[$];
  int unsigned wr_total = 0;
  int unsigned viol = 0;
  int unsigned cyc_cycles = 0;
  int unsigned err_resp_cyc = 0;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  vec_t vecs[8];

  function automatic logic [31:0] pat(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [2:0] cti_exp(input int unsigned n, input int unsigned i);
    if (n == 1) return 3'b000;
    if (i == n - 1) return 3'b111;
    return 3'b010;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scripted slave: responds on the falling edge so the DUT sees ack/err at the next rise.
  initial begin
    logic        in_beat;
    int unsigned wcnt;
    logic [29:0] h_addr;
    logic [2:0]  h_cti;
    logic [31:0] h_data;
    logic        h_we;
    beat_t       b;
    in_beat = 1'b0;
    wcnt = 0;
    h_addr = '0; h_cti = '0; h_data = '0; h_we = 1'b0;
    bus.wbm_ack_i  = 1'b0;
    bus.wbm_err_i  = 1'b0;
    bus.wbm_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        wcnt = 0;
        in_beat = 1'b0;
      end else begin
        if (done) done_q.push_back(cyc_n);
        if (err) begin
          err_q.push_back(cyc_n);
          if (bus.wbm_cyc_o) viol++;
        end
        if (bus.wbm_cyc_o) cyc_cycles++;
        if (bus.wbm_cyc_o && !busy) viol++;
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
          if (!in_beat) begin
            h_addr = bus.wbm_addr_o; h_cti = bus.wbm_cti_o;
            h_data = bus.wbm_data_o; h_we = bus.wbm_we_o;
            in_beat = 1'b1;
          end else if (h_addr !== bus.wbm_addr_o || h_cti !== bus.wbm_cti_o ||
                       h_we !== bus.wbm_we_o || (h_we && h_data !== bus.wbm_data_o)) begin
            viol++;
          end
          if (wcnt == cfg_ws) begin
            if (bus.wbm_we_o && wr_total == cfg_err_at) begin
              bus.wbm_err_i = 1'b1;
              bus.wbm_ack_i = 1'b0;
              err_resp_cyc = cyc_n;
            end else begin
              bus.wbm_err_i  = 1'b0;
              bus.wbm_ack_i  = 1'b1;
              bus.wbm_data_i = bus.wbm_we_o ? 32'h0 : pat(bus.wbm_addr_o);
              b.addr = bus.wbm_addr_o; b.we = bus.wbm_we_o; b.cti = bus.wbm_cti_o;
              b.data = bus.wbm_data_o; b.cyc = cyc_n;
              log_q.push_back(b);
              if (bus.wbm_we_o) wr_total++;
            end
            wcnt = 0;
            in_beat = 1'b0;
          end else begin
            wcnt++;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
          end
        end else begin
          bus.wbm_ack_i = 1'b0;
          bus.wbm_err_i = 1'b0;
          wcnt = 0;
          in_beat = 1'b0;
        end
      end
    end
  end

  task automatic wait_end(input int unsigned dbase, input int unsigned ebase, input string tag);
    logic finished;
    finished = 1'b0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      @(negedge clk); #1;
      if (done_q.size() > dbase || err_q.size() > ebase) finished = 1'b1;
    end
    chk({tag, "_complete"}, finished, 1'b1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned base, dbase, ebase, vbase, cbase, s_cyc, n, wcount, exp_ts, prev;
    beat_t       exp_q[$];
    beat_t       b, e;
    logic [29:0] s, d, last_wr;
    logic [15:0] rem;
    logic        stop, have_wr;
    base  = log_q.size();
    dbase = done_q.size();
    ebase = err_q.size();
    vbase = viol;
    cbase = cyc_cycles;
    cfg_ws = v.ws;
    cfg_err_at = (v.errbeat < 0) ? 32'hFFFF_FFFF : wr_total + int'(v.errbeat);
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; length = v.len; start = 1'b1;
    s_cyc = cyc_n;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, (v.len != 0));
    wait_end(dbase, ebase, tag);

    // Expected bus trace.
    s = v.src; d = v.dst; rem = v.len; wcount = 0; stop = 1'b0;
    while (rem != 0 && !stop) begin
      n = (rem > MAXB) ? MAXB : int'(rem);
      for (int unsigned i = 0; i < n; i++) begin
        e.addr = s + 30'(i); e.we = 1'b0; e.cti = cti_exp(n, i); e.data = '0; e.cyc = 0;
        exp_q.push_back(e);
      end
      for (int unsigned i = 0; i < n && !stop; i++) begin
        if (v.errbeat >= 0 && wcount == int'(v.errbeat)) begin
          stop = 1'b1;
        end else begin
          e.addr = d + 30'(i); e.we = 1'b1; e.cti = cti_exp(n, i);
          e.data = pat(s + 30'(i)); e.cyc = 0;
          exp_q.push_back(e);
          wcount++;
        end
      end
      s = s + 30'(n); d = d + 30'(n); rem = rem - 16'(n);
    end

    chk({tag, "_done_count"}, done_q.size() - dbase, v.exp_done);
    chk({tag, "_err_count"}, err_q.size() - ebase, v.exp_err);
    chk({tag, "_beat_count"}, log_q.size() - base, v.exp_beats);
    prev = 0;
    have_wr = 1'b0;
    last_wr = '0;
    for (int unsigned i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      b = log_q[base + i];
      e = exp_q[i];
      if (i == 0) exp_ts = s_cyc + 1 + v.ws;
      else exp_ts = prev + v.ws + 1 + ((exp_q[i-1].we != e.we) ? 1 : 0);
      chk($sformatf("%s_beat%0d", tag, i),
          {b.addr, b.we, b.cti, (e.we ? b.data : 32'h0), 32'(b.cyc)},
          {e.addr, e.we, e.cti, e.data, 32'(exp_ts)});
      prev = b.cyc;
    end
    for (int unsigned i = base; i < log_q.size(); i++) begin
      if (log_q[i].we) begin
        have_wr = 1'b1;
        last_wr = log_q[i].addr;
      end
    end
    if (v.exp_beats > 0) chk({tag, "_last_dst"}, {have_wr, last_wr}, {1'b1, v.exp_last_dst});
    if (v.len == 0) chk({tag, "_no_cyc"}, cyc_cycles - cbase, 0);
    if (v.exp_done != 0 && done_q.size() > dbase)
      chk({tag, "_done_cycle"}, done_q[dbase],
          (v.len == 0 || log_q.size() == base) ? s_cyc + 1 : log_q[log_q.size() - 1].cyc + 1);
    if (v.exp_err != 0 && err_q.size() > ebase)
      chk({tag, "_err_cycle"}, err_q[ebase], err_resp_cyc + 1);
    chk({tag, "_protocol"}, viol - vbase, 0);
  endtask

  initial begin
    int unsigned base, dbase, ebase;
    // len, src, dst, waits, err write beat, done, err, beats, last dst
    vecs[0] = '{16'd3,  30'h100,      30'h200,      0, -1, 1, 0, 6,  30'h202};
    vecs[1] = '{16'd20, 30'h1000,     30'h2000,     0, -1, 1, 0, 40, 30'h2013};
    vecs[2] = '{16'd1,  30'h40,       30'h80,       0, -1, 1, 0, 2,  30'h80};
    vecs[3] = '{16'd0,  30'h10,       30'h20,       0, -1, 1, 0, 0,  30'h0};
    vecs[4] = '{16'd5,  30'h300,      30'h400,      3,  1, 0, 1, 6,  30'h400};
    vecs[5] = '{16'd16, 30'h500,      30'h600,      1, -1, 1, 0, 32, 30'h60F};
    vecs[6] = '{16'd2,  30'h3FFFFFFF, 30'h3FFFFFFF, 2, -1, 1, 0, 4,  30'h0};
    vecs[7] = '{16'd17, 30'h20,       30'h3FFFFFF8, 0, -1, 1, 0, 34, 30'h8};

    #3;
    chk("reset_outputs",
        {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, busy, done, err,
         bus.wbm_addr_o, bus.wbm_cti_o, bus.wbm_data_o}, '0);
    chk("const_bte_sel", {bus.wbm_bte_o, bus.wbm_sel_o}, {2'b00, 4'hF});
    #20 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a burst.
    cfg_ws = 0;
    cfg_err_at = 32'hFFFF_FFFF;
    @(negedge clk);
    src_addr = 30'h800; dst_addr = 30'h900; length = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", bus.wbm_cyc_o, 1'b0);
    chk("rst_mid_stb", bus.wbm_stb_o, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_vec(vecs[0], "post_rst");

    // A second start while busy must be ignored.
    cfg_ws = 0;
    cfg_err_at = 32'hFFFF_FFFF;
    base  = log_q.size();
    dbase = done_q.size();
    ebase = err_q.size();
    @(negedge clk);
    src_addr = 30'h100; dst_addr = 30'h900; length = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src_addr = 30'h700; dst_addr = 30'hA00; length = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(dbase, ebase, "busy_start");
    repeat (20) @(negedge clk);
    #1;
    chk("busy_start_beats", log_q.size() - base, 8);
    chk("busy_start_done_count", done_q.size() - dbase, 1);
    if (log_q.size() >= base + 8) begin
      chk("busy_start_first_rd", {log_q[base].we, log_q[base].addr}, {1'b0, 30'h100});
      chk("busy_start_last_wr", {log_q[base + 7].we, log_q[base + 7].addr}, {1'b1, 30'h903});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dma_master.md
Name: wb_dma_master

Overview:
Wishbone master that copies a block of 32-bit words from a source address to a destination address. It runs incrementing read bursts into a local buffer, then incrementing write bursts out of it. It is the initiator counterpart of the memory slaves (RAM/PCM) and attaches to a master port of the system bus. Software or a control FSM programs it through a simple start/busy/done interface.

Parameters:
BUF_ADDR_BITS, 4, log2 of buffer depth in words; maximum burst length is 2^BUF_ADDR_BITS.
LEN_BITS, 16, width of the word-count field.

Ports:
clk  input  1  system clock; all wishbone signals are synchronous to it.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
src_addr  input  30  source word address [31:2], captured on start.
dst_addr  input  30  destination word address [31:2], captured on start.
length  input  LEN_BITS  number of words to copy, captured on start.
busy  output  1  high from the cycle after an accepted start until done/err.
done  output  1  one-cycle pulse when the copy completes.
err  output  1  one-cycle pulse on abort by a bus error.
wbm_cyc_o  output  1  wishbone cycle.
wbm_stb_o  output  1  wishbone strobe.
wbm_addr_o  output  30  wishbone word address [31:2].
wbm_cti_o  output  3  cycle type identifier.
wbm_bte_o  output  2  burst type extension; always 2'b00 (linear).
wbm_sel_o  output  4  byte select; always 4'hF.
wbm_we_o  output  1  write enable.
wbm_data_o  output  32  write data.
wbm_data_i  input  32  read data.
wbm_ack_i  input  1  acknowledge.
wbm_err_i  input  1  error.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. cyc, stb, we, busy, done and err are 0. addr, data_o and cti are 0. Any bus cycle in flight is dropped immediately. Buffer contents are don't-care.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 with length=0: go to FIN with no bus activity, so done pulses 1 cycle later.
  - start=1 with length>0: latch src, dst and remaining=length. Chunk = min(remaining, 2^BUF_ADDR_BITS). Go to RD with busy=1.
- RD:
  - Drive cyc=stb=1, we=0, addr=src.
  - On each ack, write data_i into buffer[beat], then src+1, beat+1.
  - cti: 3'b010 for every beat except the last of the chunk, which is 3'b111. A single-word chunk uses 3'b000.
  - After the last ack: deassert cyc/stb for exactly 1 cycle, then enter WR with beat=0.
- WR:
  - Same sequence with we=1, addr=dst, data_o=buffer[beat]. data_o must be valid in the same cycle stb is asserted; the buffer read is combinational or prefetched.
  - After the last ack: remaining -= chunk, then deassert cyc for 1 cycle.
  - If remaining > 0, start a new RD chunk; otherwise go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Address arithmetic wraps modulo 2^30 with no error.
- Wait states: stb stays high and addr, cti and data are held until ack.
- wbm_err_i during RD or WR:
  - Drop cyc/stb that same clock edge and pulse err for 1 cycle.
  - Return to IDLE with busy=0. No done pulse.
  - Words already written stay written.
- ack and err in the same cycle are treated as err.
- start asserted while busy is ignored.
- Overlapping source and destination ranges are not handled; results follow chunk order.
- Throughput: 1 word per cycle when the slave acks back-to-back.

Decomposition:
- Shared header (define.vh): CTI encodings CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111, and BTE_LINEAR=2'b00.
- One sub-module, wb_dma_buf: a 2^BUF_ADDR_BITS x 32 simple dual-port buffer with one write port and an asynchronous read port. It maps to distributed RAM.
- FSM and counters live in the top module.

Test Plan:
- length=3, src=0x100, dst=0x200, slave acks every cycle.
  - Expect 3 reads at addr 0x100–0x102 with cti 010,010,111.
  - Then 3 writes at 0x200–0x202 with the same cti sequence and data equal to what was read.
  - done pulses once, and busy is high throughout the copy.
- length=20, BUF_ADDR_BITS=4.
  - Expect chunks of 16 and 4: RD16, WR16, RD4, WR4.
  - The final destination address is dst+19.
  - Exactly one cycle with cyc=0 between phases.
- length=1: a single read and a single write, both with cti=000; done pulses.
- length=0: done pulses 1 cycle after start; wbm_cyc_o is never asserted.
- Slave inserts 3 wait states per beat, and asserts err on the 2nd write beat.
  - stb, addr and data are stable during the waits.
  - err pulses once, cyc drops at that edge, and there is no done pulse.
- Reset and start gating:
  - rst_n pulled low mid-burst: cyc, stb and busy go to 0 asynchronously, before the next edge.
  - After release, a new start runs a normal copy.
  - A start pulse issued while busy has no effect.
